led_breathe_pwm: RTL and testbench

- Downstream consumer of the free-running 22-bit blink counter.
- Takes the counter's one-cycle carry-out strobe as a step tick and ramps an LED duty cycle up and down, so the LED "breathes" instead of toggling.
- Contains its own PWM counter, a duty ramp FSM, and a glitch-free duty shadow register.
- Drives a board LED pin directly.

---
 rtl/led_breathe_pwm.sv | 115 +++++++++++
 tb/tb_led_breathe_pwm.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_breathe_pwm.sv
// LED "breathing" driver.
// The upstream blink counter's carry strobe steps a duty ramp up to full
// brightness, dwells there, ramps back down to off and dwells again.
// The duty is presented to a free-running PWM counter through a shadow
// register that reloads only at the period boundary, so the LED never
// shows a partially updated period.
module led_breathe_pwm #(
  parameter int N    = 8,
  parameter int HOLD = 4
) (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic         EN,
  input  logic         TICK,
  output logic         LED,
  output logic [N-1:0] DUTY,
  output logic [1:0]   STATE
);

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } state_e;

  localparam logic [N-1:0] MAX       = '1;
  localparam logic [N-1:0] ZERO      = '0;
  localparam logic [7:0]   HOLD_LAST = 8'(HOLD - 1);

  logic [N-1:0] pwmCnt_q, pwmCnt_d;
  logic [N-1:0] shadow_q, shadow_d;
  logic [N-1:0] duty_q, duty_d;
  logic [7:0]   holdCnt_q, holdCnt_d;
  state_e       state_q, state_d;
  logic         led_q, led_d;

  // PWM side: counter advance, period-boundary shadow reload and LED compare.
  always_comb begin
    pwmCnt_d = pwmCnt_q;
    shadow_d = shadow_q;
    led_d    = 1'b0;
    if (EN) begin
      pwmCnt_d = pwmCnt_q + 1'b1;
      if (pwmCnt_q == MAX) begin
        shadow_d = duty_q;
      end
      led_d = (pwmCnt_q < shadow_q);
    end
  end

  // Ramp FSM: each enabled tick steps the duty or advances the dwell count.
  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    holdCnt_d = holdCnt_q;
    if (EN && TICK) begin
      unique case (state_q)
        RISE: begin
          duty_d = duty_q + 1'b1;
          if (duty_d == MAX) begin
            state_d   = HOLD_HI;
            holdCnt_d = 8'd0;
          end
        end
        HOLD_HI: begin
          holdCnt_d = holdCnt_q + 8'd1;
          if (holdCnt_q == HOLD_LAST) begin
            state_d = FALL;
          end
        end
        FALL: begin
          duty_d = duty_q - 1'b1;
          if (duty_d == ZERO) begin
            state_d   = HOLD_LO;
            holdCnt_d = 8'd0;
          end
        end
        HOLD_LO: begin
          holdCnt_d = holdCnt_q + 8'd1;
          if (holdCnt_q == HOLD_LAST) begin
            state_d = RISE;
          end
        end
        default: begin
          state_d = RISE;
        end
      endcase
    end
  end

  // State registers; reset drops everything back to a dark LED at the ramp start.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pwmCnt_q  <= '0;
      shadow_q  <= '0;
      duty_q    <= '0;
      holdCnt_q <= 8'd0;
      state_q   <= RISE;
      led_q     <= 1'b0;
    end else begin
      pwmCnt_q  <= pwmCnt_d;
      shadow_q  <= shadow_d;
      duty_q    <= duty_d;
      holdCnt_q <= holdCnt_d;
      state_q   <= state_d;
      led_q     <= led_d;
    end
  end

  assign LED   = led_q;
  assign DUTY  = duty_q;
  assign STATE = state_q;

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Bench for the LED breathing driver (N=4, HOLD=2).
// Expected duty/state come from the position within one breath, expected
// LED on-times per period come from the duty that should be latched.
module tb_led_breathe_pwm;

  localparam int N      = 4;
  localparam int HOLDV  = 2;
  localparam int MAXV   = 15;
  localparam int BREATH = 2 * MAXV + 2 * HOLDV;

  logic         CLK = 1'b0;
  logic         RESETN;
  logic         EN;
  logic         TICK;
  logic         LED;
  logic [N-1:0] DUTY;
  logic [1:0]   STATE;

  int checks    = 0;
  int errors    = 0;
  int tickCount = 0;
  int expDutyQ[$];
  int expStateQ[$];
  int expLedQ[$];

  logic [N-1:0] tbPhase;

  led_breathe_pwm #(.N(N), .HOLD(HOLDV)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .EN     (EN),
    .TICK   (TICK),
    .LED    (LED),
    .DUTY   (DUTY),
    .STATE  (STATE)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 CLK = ~CLK;

  // Reference PWM phase: counts enabled edges since the last reset.
  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) tbPhase <= '0;
    else if (EN) tbPhase <= tbPhase + 1'b1;
  end

  // Safety net so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int expDutyAt(input int t);
    int p;
    p = t % BREATH;
    if (p < MAXV) return p;
    else if (p < MAXV + HOLDV) return MAXV;
    else if (p < 2 * MAXV + HOLDV) return 2 * MAXV + HOLDV - p;
    else return 0;
  endfunction

  function automatic int expStateAt(input int t);
    int p;
    p = t % BREATH;
    if (p < MAXV) return 0;
    else if (p < MAXV + HOLDV) return 1;
    else if (p < 2 * MAXV + HOLDV) return 2;
    else return 3;
  endfunction

  task automatic pushTick();
    tickCount++;
    expDutyQ.push_back(expDutyAt(tickCount));
    expStateQ.push_back(expStateAt(tickCount));
  endtask

  task automatic popCompare();
    if (expDutyQ.size() == 0 || expStateQ.size() == 0) begin
      checkOutput("sbEmpty", 0, 1);
    end else begin
      checkOutput("duty", int'(DUTY), expDutyQ.pop_front());
      checkOutput("state", int'(STATE), expStateQ.pop_front());
    end
  endtask

  // One single-cycle tick with its outcome scoreboarded.
  task automatic applyStimulus();
    pushTick();
    TICK = 1'b1;
    step();
    TICK = 1'b0;
    popCompare();
  endtask

  task automatic waitPhase(input int target);
    for (int i = 0; i < 64 && int'(tbPhase) != target; i++) step();
    if (int'(tbPhase) != target) checkOutput("phaseWait", int'(tbPhase), target);
  endtask

  // Counts LED on-cycles over exactly one PWM period, optionally ticking
  // on the cycle where the counter holds tickPhase.
  task automatic measurePeriod(input int tickPhase, input int expHighs);
    int highs;
    bit ticked;
    expLedQ.push_back(expHighs);
    waitPhase(1);
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      ticked = 1'b0;
      highs += int'(LED);
      if (int'(tbPhase) == tickPhase) begin
        pushTick();
        TICK   = 1'b1;
        ticked = 1'b1;
      end
      step();
      if (ticked) begin
        TICK = 1'b0;
        popCompare();
      end
    end
    checkOutput("ledHighs", highs, expLedQ.pop_front());
  endtask

  initial begin
    int highs;
    int frozenPhase;
    RESETN = 1'b0;
    EN     = 1'b0;
    TICK   = 1'b0;
    idle(3);
    checkOutput("rstLed", int'(LED), 0);
    checkOutput("rstDuty", int'(DUTY), 0);
    checkOutput("rstState", int'(STATE), 0);
    RESETN = 1'b1;
    EN     = 1'b1;
    idle(5);

    $display("[TB] ramp up");
    for (int k = 0; k < MAXV; k++) begin
      applyStimulus();
      idle(39);
    end
    measurePeriod(-1, MAXV);

    $display("[TB] rest of the breath");
    for (int k = 0; k < BREATH - MAXV; k++) begin
      applyStimulus();
      idle(2);
    end
    checkOutput("breathEndState", int'(STATE), 0);
    checkOutput("breathEndDuty", int'(DUTY), 0);

    $display("[TB] period-boundary duty update");
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      idle(2);
    end
    idle(40);
    measurePeriod(3, 5);
    measurePeriod(-1, 6);
    measurePeriod(15, 6);
    measurePeriod(-1, 6);
    measurePeriod(-1, 7);

    $display("[TB] enable freeze");
    idle(5);
    frozenPhase = int'(tbPhase);
    EN = 1'b0;
    step();
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      TICK = (i % 3 == 0);
      highs += int'(LED);
      step();
    end
    TICK = 1'b0;
    checkOutput("freezeLedHighs", highs, 0);
    checkOutput("freezeDuty", int'(DUTY), expDutyAt(tickCount));
    checkOutput("freezeState", int'(STATE), expStateAt(tickCount));
    checkOutput("freezePwm", int'(dut.pwmCnt_q), frozenPhase);
    EN = 1'b1;
    measurePeriod(-1, 7);
    checkOutput("resumePwm", int'(dut.pwmCnt_q), int'(tbPhase));

    $display("[TB] asynchronous reset mid-ramp");
    #3;
    RESETN = 1'b0;
    #1;
    checkOutput("asyncRstLed", int'(LED), 0);
    checkOutput("asyncRstDuty", int'(DUTY), 0);
    checkOutput("asyncRstState", int'(STATE), 0);
    tickCount = 0;
    step();
    step();
    RESETN = 1'b1;
    highs = 0;
    for (int i = 0; i < 64; i++) begin
      highs += int'(LED);
      step();
    end
    checkOutput("postRstLedHighs", highs, 0);

    $display("[TB] held tick");
    applyStimulus();
    applyStimulus();
    TICK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pushTick();
      step();
      popCompare();
    end
    TICK = 1'b0;
    step();
    checkOutput("heldTickDuty", int'(DUTY), 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
